// File: rtl/bmp180_i2c_slave.sv
// BMP180 pressure-sensor emulator on an I2C bus.
// Oversamples SCL/SDA with CLK. Decodes START/STOP, the address byte, the register
// pointer and data bytes. Serves chip ID, calibration bytes, ctrl_meas, soft reset and
// the ADC output registers. A write to ctrl_meas starts a conversion of fixed length,
// after which the host-supplied raw values I_UT/I_UP become readable.
//   CLK, RST_n     : system clock, asynchronous active-low reset
//   I_UT, I_UP     : raw temperature / pressure, sampled when a conversion completes
//   IO_SCL         : bus clock, only sampled (no clock stretching)
//   IO_SDA         : bus data, open-drain (0 or Z)
//   O_BUSY         : high from START until STOP
//   O_SCO, O_CTRL  : conversion-in-progress flag and the ctrl_meas register
module bmp180_i2c_slave #(
  parameter int unsigned  FPGA_CLK = 50_000_000,
  parameter logic [6:0]   DEV_ADDR = 7'h77,
  parameter logic [7:0]   CHIP_ID  = 8'h55,
  parameter logic [175:0] CALIB    = 176'h0,
  parameter int unsigned  N_CLK_T  = FPGA_CLK / 10_000 * 45,
  parameter int unsigned  N_CLK_P0 = FPGA_CLK / 10_000 * 45,
  parameter int unsigned  N_CLK_P1 = FPGA_CLK / 10_000 * 75,
  parameter int unsigned  N_CLK_P2 = FPGA_CLK / 10_000 * 135,
  parameter int unsigned  N_CLK_P3 = FPGA_CLK / 10_000 * 255
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic [15:0] I_UT,
  input  logic [18:0] I_UP,
  inout  wire         IO_SCL,
  inout  wire         IO_SDA,
  output logic        O_BUSY,
  output logic        O_SCO,
  output logic [7:0]  O_CTRL
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAckA, StReg, StAckR, StWdata, StAckW, StRdata, StMack, StWaitStop
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_q, sda_q;  // [1:0] synchronizer, [2] previous synchronized value
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sr_q, sr_d, tx_q, tx_d, ptr_q, ptr_d, ctrl_q, ctrl_d;
  logic        oe_q, oe_d, mack_q, mack_d;
  logic [23:0] out_q, out_d;
  logic [31:0] cnt_q, cnt_d;

  logic        scl_s, sda_s, scl_rise, scl_fall, start, stop, wr_en;
  logic [7:0]  rd_data, cal_idx;
  logic [175:0] calib_sh;
  logic [23:0] up_val;
  logic [31:0] n_p;

  assign scl_s    = scl_q[1];
  assign sda_s    = sda_q[1];
  assign scl_rise = scl_s & ~scl_q[2];
  assign scl_fall = ~scl_s & scl_q[2];
  assign start    = scl_s & scl_q[2] & sda_q[2] & ~sda_s;
  assign stop     = scl_s & scl_q[2] & ~sda_q[2] & sda_s;

  assign IO_SDA = oe_q ? 1'b0 : 1'bz;
  assign O_BUSY = (state_q != StIdle);
  assign O_SCO  = ctrl_q[5];
  assign O_CTRL = ctrl_q;

  // Read map
  always_comb begin
    cal_idx  = ptr_q - 8'hAA;
    calib_sh = CALIB << {cal_idx, 3'b000};
    case (ptr_q)
      8'hD0:   rd_data = CHIP_ID;
      8'hF4:   rd_data = ctrl_q;
      8'hF6:   rd_data = out_q[23:16];
      8'hF7:   rd_data = out_q[15:8];
      8'hF8:   rd_data = out_q[7:0];
      default: rd_data = (ptr_q >= 8'hAA && ptr_q <= 8'hBF) ? calib_sh[175:168] : 8'h00;
    endcase
  end

  // Pressure result is left-aligned by (8 - oss) into the 24-bit output register.
  assign up_val = {5'b0, I_UP} << (4'd8 - {2'b00, ctrl_q[7:6]});

  always_comb begin
    case (sr_q[7:6])
      2'd0:    n_p = N_CLK_P0;
      2'd1:    n_p = N_CLK_P1;
      2'd2:    n_p = N_CLK_P2;
      default: n_p = N_CLK_P3;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    oe_d      = oe_q;
    mack_d    = mack_q;
    ctrl_d    = ctrl_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;

    if (start) begin
      state_d   = StAddr;
      bit_cnt_d = 3'd0;
      oe_d      = 1'b0;
    end else if (stop) begin
      state_d = StIdle;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        StAddr, StReg, StWdata: begin
          if (scl_rise) begin
            sr_d      = {sr_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                state_d = (sr_q[6:0] == DEV_ADDR) ? StAckA : StWaitStop;
              end else begin
                state_d = (state_q == StReg) ? StAckR : StAckW;
              end
            end
          end
        end
        StAckA, StAckR, StAckW: begin
          if (scl_rise && state_q == StAckR) ptr_d = sr_q;
          if (scl_rise && state_q == StAckW) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 8'd1;
          end
          // First fall after the byte pulls SDA low, the next one releases it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d      = 1'b0;
              bit_cnt_d = 3'd0;
              if (state_q == StAckA && sr_q[0]) begin
                state_d = StRdata;
                tx_d    = rd_data;
                oe_d    = ~rd_data[7];
              end else begin
                state_d = (state_q == StAckA) ? StReg : StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_rise) bit_cnt_d = bit_cnt_q + 3'd1;
          if (scl_fall) begin
            if (bit_cnt_q == 3'd0) begin  // all 8 bits clocked out
              oe_d    = 1'b0;
              state_d = StMack;
              ptr_d   = ptr_q + 8'd1;
            end else begin
              oe_d = ~tx_q[3'd7 - bit_cnt_q];
            end
          end
        end
        StMack: begin
          if (scl_rise) mack_d = ~sda_s;
          if (scl_fall) begin
            if (mack_q) begin
              state_d   = StRdata;
              tx_d      = rd_data;
              oe_d      = ~rd_data[7];
              bit_cnt_d = 3'd0;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        default: ;
      endcase
    end

    // Conversion countdown; bit 5 of ctrl is the busy flag.
    if (ctrl_q[5]) begin
      if (cnt_q == 32'd0) begin
        ctrl_d[5] = 1'b0;
        out_d     = (ctrl_q[4:0] == 5'h14) ? up_val : {I_UT, 8'h00};
      end else begin
        cnt_d = cnt_q - 32'd1;
      end
    end

    // Bus writes take priority over a completion in the same cycle.
    if (wr_en) begin
      if (ptr_q == 8'hF4) begin
        ctrl_d = sr_q;
        if (sr_q[4:0] == 5'h0E) begin
          ctrl_d[5] = 1'b1;
          cnt_d     = N_CLK_T - 32'd1;
        end else if (sr_q[4:0] == 5'h14) begin
          ctrl_d[5] = 1'b1;
          cnt_d     = n_p - 32'd1;
        end else begin
          ctrl_d[5] = 1'b0;
        end
      end else if (ptr_q == 8'hE0 && sr_q == 8'hB6) begin
        ctrl_d = 8'h00;
        out_d  = 24'h0;
        cnt_d  = 32'd0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      sr_q      <= 8'h00;
      tx_q      <= 8'h00;
      ptr_q     <= 8'h00;
      oe_q      <= 1'b0;
      mack_q    <= 1'b0;
      ctrl_q    <= 8'h00;
      out_q     <= 24'h0;
      cnt_q     <= 32'd0;
    end else begin
      scl_q     <= {scl_q[1:0], IO_SCL};
      sda_q     <= {sda_q[1:0], IO_SDA};
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      oe_q      <= oe_d;
      mack_q    <= mack_d;
      ctrl_q    <= ctrl_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
